gated_counter: RTL and testbench
================================

# gated_counter

Parametrised multi-mode counter for the FSK demodulator datapath. It counts in one of four runtime-selectable modes: free-run, modulo, one-shot and down-reload. An asynchronous `gate` input is synchronised internally; on each rising edge of `gate` the block captures the running count, so the demodulator can measure the period between signal edges. The block generalises the fixed 15-bit free-running counter used in the demodulator.

## Interface
- `WIDTH`, 15: counter, limit and capture width (≥2).
- `SYNC_STAGES`, 2: synchroniser flops on `gate` (≥2).
- `RESTART_ON_GATE`, 1: 1 = a gate rising edge also restarts the counter; 0 = capture only.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: count enable.
- `clr` in 1: synchronous clear.
- `mode` in 2: 00 FREE, 01 MOD, 10 ONESHOT, 11 DOWN.
- `limit` in WIDTH: terminal value for MOD, ONESHOT and DOWN. Sampled every cycle.
- `gate` in 1: asynchronous measurement input.
- `count` out WIDTH: current count (registered).
- `tc` out 1: terminal-count pulse, 1 cycle, registered.
- `done` out 1: ONESHOT complete, level.
- `cap_val` out WIDTH: count captured at the last gate edge.
- `cap_valid` out 1: 1-cycle pulse when `cap_val` updates.
- `cap_ovf` out 1: set with `cap_val` if a wrap occurred since the previous capture/restart/clear.

## Operation
- Reset (async): `count`, `cap_val` = 0. `tc`, `done`, `cap_valid`, `cap_ovf`, the internal wrap flag and all synchroniser/edge flops = 0.
- Priority per cycle: `clr` > gate restart > `en` counting > hold.
- `clr`: `count` ← 0 (← `limit` in DOWN). `done`, `tc` and the wrap flag ← 0. Capture is unaffected.
- Gate restart (RESTART_ON_GATE=1, edge detected): `count` ← 0 (← `limit` in DOWN). `done`, `tc` and the wrap flag ← 0.
- `en`=0 with no clr/restart: `count` and `done` hold, `tc`=0.
- FREE: `count` ← `count`+1 mod 2^WIDTH. When all-ones → 0, `tc`=1 and the wrap flag is set.
- MOD: if `count` ≥ `limit` then `count` ← 0, `tc`=1, wrap flag set; else `count`+1. With `limit`=0, `count` stays 0 and `tc` pulses on every enabled cycle.
- ONESHOT: if `count` ≥ `limit`, hold and set `done` (no `tc`). Otherwise `count`+1; if the result equals `limit`, `tc`=1 and `done`=1. `done` stays high until clr, restart or reset.
- DOWN: if `count`=0 then `count` ← `limit`, `tc`=1, wrap flag set; else `count`−1.
- `mode` changes take effect on the next enabled cycle from the current `count`. No implicit clear.
- Capture: on a synchronised rising edge, `cap_val` ← `count` (the value before any restart that same cycle), `cap_ovf` ← wrap flag, `cap_valid`=1. The wrap flag is then cleared.
- A wrap in the same cycle as the capture edge is not included in that capture. It sets the flag unless a restart or clr also occurs that cycle.
- `clr` and a gate edge in the same cycle: the capture still occurs, then the clear applies.

## Timing
- `count`, `tc` and `done` update one cycle after the qualifying edge. `tc` is coincident with the new `count` (0 after wrap, `limit` after DOWN reload or ONESHOT completion).
- Gate path: if `gate` is first sampled high at edge k, `cap_valid` is high for the single cycle after edge k+SYNC_STAGES.
- `cap_val` is the `count` presented during the cycle preceding that edge. The restart takes effect on the same edge.
- Gate pulses shorter than 2 clk periods or closer than SYNC_STAGES+1 cycles are not guaranteed to be detected.
- Synchroniser flops reset to 0, so `gate` high at reset release produces one capture.
- Asserting `reset` mid-count clears all state immediately and asynchronously. Deasserting it does not generate `tc`.

## Test plan
- FREE, WIDTH=4, `en`=1 from reset: `count` runs 0..15,0. `tc` is high only with `count`=0 after the wrap (cycle 16). `done` stays 0.
- MOD, `limit`=5: sequence 0,1,2,3,4,5,0 with `tc` at each 0. Change `limit` to 2 while `count`=4: the next value is 0 with `tc`. With `limit`=0, `count` stays 0 and `tc` is high every cycle.
- ONESHOT, `limit`=3: `count` 1,2,3 then holds; `tc`=1 and `done`=1 with `count`=3. `clr` clears `done` and `count` to 0. Set `limit`=2 while `count`=3: `done` is 1 and `tc` stays 0.
- DOWN, `limit`=3, after `clr`: `count` 3,2,1,0,3. `tc` is high with the reloaded 3. `en`=0 holds the value.
- Capture, RESTART_ON_GATE=1, FREE, SYNC_STAGES=2: gate edges 10 cycles apart give `cap_val`=9, `cap_ovf`=0 and `cap_valid` 3 cycles after the gate rise. With WIDTH=3 and edges 12 cycles apart, `cap_ovf`=1.
- Assert `reset` mid-count with `gate` high: every output is 0 immediately. After release, one capture occurs with `cap_val`=0 and `cap_ovf`=0.

Source files
------------

// File: rtl/gated_counter.sv
// gated_counter: multi-mode counter with synchronised gate capture.
//   Counts in FREE, MOD, ONESHOT or DOWN mode (selected at runtime by
//   `mode`). A rising edge on the asynchronous `gate` input is synchronised
//   and captures the running count. It can optionally restart the counter,
//   which gives a period measurement between gate edges.
// Ports:
//   clk, reset      - clock (rising edge) and asynchronous active-high reset
//   en, clr         - count enable, synchronous clear (clr has priority)
//   mode[1:0]       - 00 FREE, 01 MOD, 10 ONESHOT, 11 DOWN
//   limit[WIDTH]    - terminal value for MOD/ONESHOT/DOWN, sampled every cycle
//   gate            - asynchronous measurement input
//   count, tc, done - registered count, 1-cycle terminal pulse, oneshot level
//   cap_val, cap_valid, cap_ovf - captured count, update pulse, wrap-seen flag
module gated_counter #(
  parameter int WIDTH           = 15,
  parameter int SYNC_STAGES     = 2,
  parameter bit RESTART_ON_GATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             gate,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic [WIDTH-1:0] cap_val,
  output logic             cap_valid,
  output logic             cap_ovf
);

  localparam logic [1:0] M_FREE    = 2'b00;
  localparam logic [1:0] M_MOD     = 2'b01;
  localparam logic [1:0] M_ONESHOT = 2'b10;
  localparam logic [1:0] M_DOWN    = 2'b11;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   gprev_q, gprev_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   tc_q, tc_d;
  logic                   done_q, done_d;
  logic                   wrap_q, wrap_d;
  logic [WIDTH-1:0]       cap_val_q, cap_val_d;
  logic                   cap_valid_q, cap_valid_d;
  logic                   cap_ovf_q, cap_ovf_d;

  logic             gate_edge;
  logic             restart;
  logic             wrap_evt;
  logic [WIDTH-1:0] reload;

  // The last synchroniser stage is compared with one more flop to find the edge.
  assign gate_edge = sync_q[SYNC_STAGES-1] & ~gprev_q;
  assign restart   = RESTART_ON_GATE & gate_edge;
  assign reload    = (mode == M_DOWN) ? limit : '0;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], gate};
    gprev_d     = sync_q[SYNC_STAGES-1];
    count_d     = count_q;
    tc_d        = 1'b0;
    done_d      = done_q;
    wrap_evt    = 1'b0;
    cap_val_d   = cap_val_q;
    cap_valid_d = 1'b0;
    cap_ovf_d   = cap_ovf_q;

    // Capture always sees the pre-restart count and the wrap flag as it was
    // before this cycle's counting step.
    if (gate_edge) begin
      cap_val_d   = count_q;
      cap_ovf_d   = wrap_q;
      cap_valid_d = 1'b1;
    end

    if (clr || restart) begin
      count_d = reload;
      done_d  = 1'b0;
    end else if (en) begin
      case (mode)
        M_FREE: begin
          count_d = count_q + ONE;
          if (count_q == ONES) begin
            tc_d     = 1'b1;
            wrap_evt = 1'b1;
          end
        end
        M_MOD: begin
          if (count_q >= limit) begin
            count_d  = '0;
            tc_d     = 1'b1;
            wrap_evt = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
        M_ONESHOT: begin
          // At or past the limit (including after a limit change) it parks
          // and reports done without another tc.
          if (count_q >= limit) begin
            done_d = 1'b1;
          end else begin
            count_d = count_q + ONE;
            if (count_q + ONE == limit) begin
              tc_d   = 1'b1;
              done_d = 1'b1;
            end
          end
        end
        M_DOWN: begin
          if (count_q == '0) begin
            count_d  = limit;
            tc_d     = 1'b1;
            wrap_evt = 1'b1;
          end else begin
            count_d = count_q - ONE;
          end
        end
        default: count_d = count_q;
      endcase
    end

    // A capture consumes the flag; a wrap in the same cycle starts the next
    // interval, unless clr/restart discards it.
    wrap_d = (wrap_q & ~gate_edge) | wrap_evt;
    if (clr || restart) wrap_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      gprev_q     <= 1'b0;
      count_q     <= '0;
      tc_q        <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      cap_val_q   <= '0;
      cap_valid_q <= 1'b0;
      cap_ovf_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      gprev_q     <= gprev_d;
      count_q     <= count_d;
      tc_q        <= tc_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      cap_val_q   <= cap_val_d;
      cap_valid_q <= cap_valid_d;
      cap_ovf_q   <= cap_ovf_d;
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign done      = done_q;
  assign cap_val   = cap_val_q;
  assign cap_valid = cap_valid_q;
  assign cap_ovf   = cap_ovf_q;

endmodule

// File: tb/tb_gated_counter.sv
module tb_gated_counter;
  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int MAXV = (1 << W) - 1;

  logic         clk, reset, en, clr, gate;
  logic [1:0]   mode;
  logic [W-1:0] lim;
  logic [W-1:0] count, cap_val;
  logic         tc, done, cap_valid, cap_ovf;

  gated_counter #(.WIDTH(W), .SYNC_STAGES(SYNC), .RESTART_ON_GATE(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .limit(lim),
    .gate(gate), .count(count), .tc(tc), .done(done), .cap_val(cap_val),
    .cap_valid(cap_valid), .cap_ovf(cap_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // gh[i] = gate level sampled i clock edges ago (gh[0] = this edge).
  bit gh[SYNC+2];
  int m_cnt, m_capv;
  bit m_tc, m_done, m_wrap, m_capvld, m_capovf;

  function automatic void model_reset();
    foreach (gh[i]) gh[i] = 1'b0;
    m_cnt = 0; m_capv = 0;
    m_tc = 0; m_done = 0; m_wrap = 0; m_capvld = 0; m_capovf = 0;
  endfunction

  function automatic void model_step();
    bit edge_det;
    for (int i = SYNC + 1; i > 0; i--) gh[i] = gh[i-1];
    gh[0] = gate;
    // Gate seen high SYNC edges ago, low the edge before that.
    edge_det = gh[SYNC] && !gh[SYNC+1];
    m_capvld = edge_det;
    if (edge_det) begin
      m_capv   = m_cnt;
      m_capovf = m_wrap;
      m_wrap   = 0;
    end
    m_tc = 0;
    if (clr || edge_det) begin
      m_cnt  = (mode == 2'd3) ? int'(lim) : 0;
      m_done = 0;
      m_wrap = 0;
    end else if (en) begin
      case (mode)
        2'd0: begin
          m_cnt = (m_cnt + 1) % (MAXV + 1);
          if (m_cnt == 0) begin m_tc = 1; m_wrap = 1; end
        end
        2'd1: if (m_cnt >= int'(lim)) begin m_cnt = 0; m_tc = 1; m_wrap = 1; end
              else m_cnt = m_cnt + 1;
        2'd2: if (m_cnt >= int'(lim)) m_done = 1;
              else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == int'(lim)) begin m_tc = 1; m_done = 1; end
              end
        default: if (m_cnt == 0) begin m_cnt = int'(lim); m_tc = 1; m_wrap = 1; end
                 else m_cnt = m_cnt - 1;
      endcase
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         clr, en;
    logic [1:0]   mode;
    logic [W-1:0] lim;
    logic [W-1:0] ecnt;
    logic         etc, edone;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input logic c, input logic e, input logic [1:0] m,
                              input int l, input int cnt, input logic t, input logic d);
    vec_t v;
    v.clr = c; v.en = e; v.mode = m; v.lim = W'(l);
    v.ecnt = W'(cnt); v.etc = t; v.edone = d;
    vt.push_back(v);
  endfunction

  // One gate period: high for 3 edges, low for the rest. The capture lands on
  // the 3rd edge and measures the previous period.
  task automatic gate_period(input int period, input int ev, input bit eo, input bit chk_val);
    for (int i = 1; i <= period; i++) begin
      gate = (i <= 3);
      tick();
      chk($sformatf("cap_valid_p%0d_i%0d", period, i), 32'(cap_valid), 32'(i == 3));
      if (i == 3 && chk_val) begin
        chk($sformatf("cap_val_p%0d", period), 32'(cap_val), 32'(ev));
        chk($sformatf("cap_ovf_p%0d", period), 32'(cap_ovf), 32'(eo));
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 0; clr = 0; gate = 0; mode = 0; lim = 0;
    model_reset();
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_tc", 32'(tc), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cap_val", 32'(cap_val), 0);
    chk("rst_cap_valid", 32'(cap_valid), 0);
    chk("rst_cap_ovf", 32'(cap_ovf), 0);
    reset = 1'b0;

    // FREE: 1..15 then 0 with tc
    for (int i = 1; i <= 16; i++) add(0, 1, 2'd0, 0, i % 16, i == 16, 0);
    // Wrap at limit 5, then limit drops to 2 at count 4, then limit 0
    for (int i = 1; i <= 5; i++) add(0, 1, 2'd1, 5, i, 0, 0);
    add(0, 1, 2'd1, 5, 0, 1, 0);
    for (int i = 1; i <= 4; i++) add(0, 1, 2'd1, 5, i, 0, 0);
    add(0, 1, 2'd1, 2, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 2'd1, 0, 0, 1, 0);
    // ONESHOT limit 3
    add(1, 1, 2'd2, 3, 0, 0, 0);
    add(0, 1, 2'd2, 3, 1, 0, 0);
    add(0, 1, 2'd2, 3, 2, 0, 0);
    add(0, 1, 2'd2, 3, 3, 1, 1);
    add(0, 1, 2'd2, 3, 3, 0, 1);
    add(0, 0, 2'd2, 3, 3, 0, 1);
    add(0, 1, 2'd2, 2, 3, 0, 1);
    add(1, 0, 2'd2, 2, 0, 0, 0);
    // DOWN limit 3
    add(1, 0, 2'd3, 3, 3, 0, 0);
    add(0, 1, 2'd3, 3, 2, 0, 0);
    add(0, 1, 2'd3, 3, 1, 0, 0);
    add(0, 1, 2'd3, 3, 0, 0, 0);
    add(0, 1, 2'd3, 3, 3, 1, 0);
    add(0, 0, 2'd3, 3, 3, 0, 0);
    add(0, 0, 2'd3, 3, 3, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      clr = vt[i].clr; en = vt[i].en; mode = vt[i].mode; lim = vt[i].lim; gate = 0;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].ecnt));
      chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(vt[i].etc));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].edone));
    end

    // Capture / restart in FREE mode
    clr = 1; en = 1; mode = 2'd0; lim = 0; gate = 0;
    tick();
    clr = 0;
    gate_period(10, 0, 0, 0);
    gate_period(10, 9, 0, 1);
    gate_period(20, 9, 0, 1);
    gate_period(10, 3, 1, 1);

    // Async reset mid-count with gate high
    gate = 1; en = 1; mode = 2'd0;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_count", 32'(count), 0);
    chk("arst_tc", 32'(tc), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_cap_val", 32'(cap_val), 0);
    chk("arst_cap_valid", 32'(cap_valid), 0);
    chk("arst_cap_ovf", 32'(cap_ovf), 0);
    en = 0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("post_rst_cap_valid_%0d", i), 32'(cap_valid), 32'(i == 3));
      chk($sformatf("post_rst_tc_%0d", i), 32'(tc), 0);
      if (i == 3) begin
        chk("post_rst_cap_val", 32'(cap_val), 0);
        chk("post_rst_cap_ovf", 32'(cap_ovf), 0);
      end
    end

    // Randomised run against the reference model
    for (int c = 0; c < 3000; c++) begin
      clr = ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  lim  = W'($urandom_range(0, MAXV));
      if ($urandom_range(0, 5) == 0)  gate = ~gate;
      tick();
      chk($sformatf("rnd%0d_count", c), 32'(count), 32'(m_cnt));
      chk($sformatf("rnd%0d_tc", c), 32'(tc), 32'(m_tc));
      chk($sformatf("rnd%0d_done", c), 32'(done), 32'(m_done));
      chk($sformatf("rnd%0d_cap_val", c), 32'(cap_val), 32'(m_capv));
      chk($sformatf("rnd%0d_cap_valid", c), 32'(cap_valid), 32'(m_capvld));
      chk($sformatf("rnd%0d_cap_ovf", c), 32'(cap_ovf), 32'(m_capovf));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
